nf_reg_file_clr: RTL and testbench
==================================

// Module: nf_reg_file_clr
// PURPOSE
//  Integer register file with hardware clear, sitting in the decode stage directly upstream of the hazard bypass unit.
//  Supplies rd1/rd2 (decode-stage read data) that the bypass unit forwards or overrides with MEM/WB results.
//  Storage is not reset, so it maps to RAM/LUT-RAM. Instead, a post-reset sweep FSM zeroes x1..x31 while holding the pipeline via init_busy.
//  Optional write-through makes a same-cycle WB write visible on the read ports, so no WB->ID bypass path is needed.
// PARAMETERS
//  ADDR_W      5    register address width; depth = 2**ADDR_W
//  DATA_W      32   register data width
//  WR_THROUGH  1    1: same-cycle write data forwarded to the read ports; 0: reads return the stored value only
// PORTS
//  clk        in   1       core clock; all state updates on the rising edge
//  rst        in   1       synchronous reset, active-high
//  ra1        in   ADDR_W  read address 1 (decode stage)
//  rd1        out  DATA_W  read data 1, combinational
//  ra2        in   ADDR_W  read address 2 (decode stage)
//  rd2        out  DATA_W  read data 2, combinational
//  wa3        in   ADDR_W  write address (write-back stage)
//  wd3        in   DATA_W  write data (write-back stage)
//  we3        in   1       write enable (write-back stage)
//  init_busy  out  1       1 while clearing; the hazard unit stalls IF/ID and flushes EXE while this is high
// BEHAVIOUR
//  Interface (already decided): a single clock, clk; reset rst is synchronous and active-high.
//  FSM states:
//   - RF_CLEAR (reset state).
//   - RF_RUN.
//  Registers:
//   - 2-bit state.
//   - ADDR_W-bit clr_cnt.
//   - storage array mem[1 .. 2**ADDR_W-1]. x0 has no storage.
//  Reset (rst=1 at an edge):
//   - state <= RF_CLEAR and clr_cnt <= 1. No write to mem that cycle.
//   - mem is not reset directly.
//  RF_CLEAR, each cycle with rst=0:
//   - mem[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1.
//   - When clr_cnt == 2**ADDR_W-1: write 0, then state <= RF_RUN and clr_cnt <= 0.
//   - Sweep latency: 2**ADDR_W-1 cycles after rst deasserts (31 at default). The first RUN cycle is the 32nd edge after deassertion.
//  init_busy:
//   - Combinational: 1 iff state==RF_CLEAR.
//   - Therefore 1 during rst and after reset.
//  Reads in RF_CLEAR:
//   - rd1 = rd2 = 0 regardless of address.
//   - we3 is ignored and does not disturb the sweep.
//  Reads in RF_RUN, fully combinational, for port n:
//   - ran == 0 -> rdn = 0 (x0 hardwired).
//   - else WR_THROUGH && we3 && wa3==ran -> rdn = wd3.
//   - else -> rdn = mem[ran].
//  Writes in RF_RUN:
//   - we3 && wa3 != 0 -> mem[wa3] <= wd3 at the edge.
//   - Writes to x0 are dropped.
//  Boundary conditions:
//   - ra1==ra2: both ports return identical data, including the write-through case.
//   - Reset mid-sweep or in RUN: restarts the sweep at 1. Any write presented in the reset cycle is discarded.
//   - Illegal state encoding: next state = RF_CLEAR (self-recovery).
//   - clr_cnt wrap is impossible: the exit is taken at the max value.
//   - WR_THROUGH=0 with a same-cycle read/write: returns the old value. The bypass unit's WB path covers this case.
//  Outputs after reset: init_busy=1, rd1=0, rd2=0.
// STRUCTURE
//  Shared cpu include/package:
//   - typedef enum logic [1:0] rf_state_t {RF_CLEAR, RF_RUN}.
//   - constants RF_ADDR_W=5 and RF_DATA_W=32, reused by the decode stage and nf_hz_bypass_unit.
//  One natural sub-module: nf_rf_clr_fsm.
//   - Contents: the state register and clr_cnt.
//   - Outputs: clr_we, clr_addr, init_busy.
//  Top: storage array, write mux (clear vs. WB) and the two read muxes.
//  Storage is written from one process only (single write port) so synthesis infers distributed RAM.
// TESTING
//  Reset pulse 1 cycle, then hold rst=0:
//   - init_busy=1 for exactly 31 cycles, then 0.
//   - After the sweep, read all x1..x31 -> 0.
//   - Preload random values into the array before reset to prove the clear.
//  RUN, write 0xDEADBEEF to x5 with ra1=5 in the same cycle:
//   - WR_THROUGH=1: rd1=0xDEADBEEF that cycle.
//   - WR_THROUGH=0: rd1=old value that cycle, 0xDEADBEEF the next cycle.
//  Write 0x12345678 to x0, ra1=ra2=0 -> rd1=rd2=0 the same cycle and all later cycles.
//  Assert rst at sweep cycle 10 for 1 cycle:
//   - init_busy stays 1 for a further 31 cycles.
//   - A we3=1 write to x3 during the sweep is lost; x3 reads 0 after the sweep.
//  Random regression, 10k cycles:
//   - Random we3/wa3/wd3/ra1/ra2 checked against a reference model (x0=0, write-through per WR_THROUGH).
//   - Sporadic rst: outputs must match the model each cycle.
//  ra1=ra2=7 while writing 0xA5A5A5A5 to x7 -> rd1=rd2=0xA5A5A5A5 (WR_THROUGH=1).

Source files
------------

// File: rtl/nf_reg_file_clr_pkg.sv
// Shared register-file types and sizes used by decode and the bypass unit.
// Both see the same state encoding and address/data widths.
package nf_reg_file_clr_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        RF_CLEAR = 2'd0,
        RF_RUN   = 2'd1
    } rf_state_t;

endpackage

// File: rtl/nf_rf_clr_fsm.sv
// Post-reset clear sequencer. It walks x1..x(2**ADDR_W-1) writing zero and
// holds init_busy until the walk is complete.
module nf_rf_clr_fsm
    import nf_reg_file_clr_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        clr_addr  = clr_cnt_q;
        init_busy = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                init_busy = 1'b1;
                // The reset cycle itself must not touch storage.
                clr_we    = !rst;
                if (clr_cnt_q == CNT_MAX) begin
                    state_d   = RF_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_ONE;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_cnt_d = CNT_ONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= CNT_ONE;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

endmodule

// File: rtl/nf_reg_file_clr.sv
// Two-read, one-write integer register file with hardware clear after reset.
// x0 reads as zero. Same-cycle WB data can optionally be forwarded to the read ports.
module nf_reg_file_clr
    import nf_reg_file_clr_pkg::*;
#(
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int DATA_W     = RF_DATA_W,
    parameter int WR_THROUGH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we3,
    output logic              init_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [1:DEPTH-1];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    nf_rf_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    // The sweep owns the write port while busy; WB writes are ignored then.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_addr;
        mem_wd = '0;
        if (clr_we) begin
            mem_we = 1'b1;
        end else if (!init_busy && !rst && we3 && (wa3 != '0)) begin
            mem_we = 1'b1;
            mem_wa = wa3;
            mem_wd = wd3;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    logic [1:0][ADDR_W-1:0] ra_all;
    logic [1:0][DATA_W-1:0] rd_all;

    assign ra_all[0] = ra1;
    assign ra_all[1] = ra2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [DATA_W-1:0] rd_sel;

        always_comb begin
            rd_sel = '0;
            if (!init_busy && (ra_all[gi] != '0)) begin
                if ((WR_THROUGH != 0) && we3 && (wa3 == ra_all[gi])) begin
                    rd_sel = wd3;
                end else begin
                    rd_sel = mem[ra_all[gi]];
                end
            end
        end

        assign rd_all[gi] = rd_sel;
    end

    assign rd1 = rd_all[0];
    assign rd2 = rd_all[1];

endmodule

// File: tb/tb_nf_reg_file_clr.sv
// Randomised and directed bench for nf_reg_file_clr, running write-through and
// non-write-through instances side by side against an array reference model.
module tb_nf_reg_file_clr;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa3;
    logic [31:0] wd3;
    logic        we3;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: sweep_left counts the busy cycles still to come.
    logic [31:0] model_mem [32];
    int          sweep_left  = 31;
    bit          model_valid = 0;

    nf_reg_file_clr #(.ADDR_W(5), .DATA_W(32), .WR_THROUGH(1)) dut_wt (
        .clk(clk), .rst(rst), .ra1(ra1), .rd1(rd1_a), .ra2(ra2), .rd2(rd2_a),
        .wa3(wa3), .wd3(wd3), .we3(we3), .init_busy(busy_a)
    );

    nf_reg_file_clr #(.ADDR_W(5), .DATA_W(32), .WR_THROUGH(0)) dut_nwt (
        .clk(clk), .rst(rst), .ra1(ra1), .rd1(rd1_b), .ra2(ra2), .rd2(rd2_b),
        .wa3(wa3), .wd3(wd3), .we3(we3), .init_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit wt);
        if (sweep_left > 0 || ra == 5'd0) return 32'd0;
        if (wt && we3 && wa3 == ra) return wd3;
        return model_mem[ra];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
            sweep_left  = 31;
            model_valid = 1;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (we3 && wa3 != 5'd0) begin
            model_mem[wa3] = wd3;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cmp_busy_wt",  {31'd0, busy_a}, {31'd0, sweep_left > 0});
            chk("cmp_busy_nwt", {31'd0, busy_b}, {31'd0, sweep_left > 0});
            chk("cmp_rd1_wt",   rd1_a, exp_rd(ra1, 1'b1));
            chk("cmp_rd2_wt",   rd2_a, exp_rd(ra2, 1'b1));
            chk("cmp_rd1_nwt",  rd1_b, exp_rd(ra1, 1'b0));
            chk("cmp_rd2_nwt",  rd2_b, exp_rd(ra2, 1'b0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles; keeps any WB write asserted for the first 5 only.
    task automatic count_sweep(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
            @(posedge clk);
            #1;
            if (n >= 5) we3 = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(32 - i);
            @(negedge clk);
            chk({tag, "_rd1"}, rd1_a, 32'd0);
            chk({tag, "_rd2"}, rd2_b, 32'd0);
            step();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; we3 = 1'b0; wa3 = 5'd0; wd3 = 32'd0; ra1 = 5'd5; ra2 = 5'd9;
        step();
        @(negedge clk);
        chk("reset_busy", {31'd0, busy_a}, 32'd1);
        chk("reset_rd1",  rd1_a, 32'd0);
        chk("reset_rd2",  rd2_a, 32'd0);
        step();
        rst = 1'b0;
        count_sweep(n);
        chk("sweep_len_first", 32'(n), 32'd31);
        step();
        check_all_zero("post_sweep");

        // Fill with random data, then reset to show the sweep clears it.
        for (int i = 1; i < 32; i++) begin
            we3 = 1'b1; wa3 = 5'(i); wd3 = $urandom; ra1 = 5'(i); ra2 = 5'(i - 1);
            step();
        end
        we3 = 1'b0;
        ra1 = 5'd17;
        @(negedge clk);
        chk("preload_nonzero", {31'd0, rd1_a == 32'd0}, {31'd0, model_mem[17] == 32'd0});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_sweep(n);
        chk("sweep_len_clear", 32'(n), 32'd31);
        step();
        check_all_zero("cleared");

        // Same-cycle write/read of x5.
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h1111_1111;
        step();
        wd3 = 32'hDEAD_BEEF; ra1 = 5'd5;
        @(negedge clk);
        chk("wt_same_cycle",  rd1_a, 32'hDEAD_BEEF);
        chk("nwt_same_cycle", rd1_b, 32'h1111_1111);
        step();
        we3 = 1'b0;
        @(negedge clk);
        chk("nwt_next_cycle", rd1_b, 32'hDEAD_BEEF);
        step();

        // x0 is hardwired to zero.
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234_5678; ra1 = 5'd0; ra2 = 5'd0;
        @(negedge clk);
        chk("x0_same_rd1", rd1_a, 32'd0);
        chk("x0_same_rd2", rd2_a, 32'd0);
        step();
        we3 = 1'b0;
        @(negedge clk);
        chk("x0_later_rd1", rd1_a, 32'd0);
        chk("x0_later_rd2", rd2_b, 32'd0);
        step();

        // Both ports on the write-through address.
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hA5A5_A5A5; ra1 = 5'd7; ra2 = 5'd7;
        @(negedge clk);
        chk("dual_wt_rd1", rd1_a, 32'hA5A5_A5A5);
        chk("dual_wt_rd2", rd2_a, 32'hA5A5_A5A5);
        step();
        we3 = 1'b0;

        // Reset at sweep cycle 10, with writes to x3 during reset and sweep.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        count_sweep(n);
        chk("sweep_len_restart", 32'(n), 32'd31);
        step();
        we3 = 1'b0; ra1 = 5'd3; ra2 = 5'd3;
        @(negedge clk);
        chk("x3_lost_wt",  rd1_a, 32'd0);
        chk("x3_lost_nwt", rd2_b, 32'd0);
        step();

        // Random regression with sporadic reset.
        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom);
            wd3 = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom);
            step();
        end
        rst = 1'b0; we3 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
